// File: rtl/clk_gate_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clk_gate_ctrl_pkg
// Shared types and helpers for the automatic clock-gating controller.
//   cg_state_e  : per-domain FSM state (2-bit encoding)
//   cg_outs_t   : bundle of the four per-domain outputs decoded from state
//   cg_decode   : state -> output bundle
//   cg_cnt_width: counter width able to hold 0..n-1 (minimum 1 bit)
// -----------------------------------------------------------------------------
package clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        CG_RUN   = 2'd0,
        CG_DRAIN = 2'd1,
        CG_GATED = 2'd2,
        CG_WAKE  = 2'd3
    } cg_state_e;

    typedef struct packed {
        logic sleep_req;
        logic clk_en;
        logic dom_ready;
        logic dom_gated;
    } cg_outs_t;

    // Output values while in (or reset into) RUN.
    localparam cg_outs_t CG_OUTS_RESET = '{
        sleep_req: 1'b0,
        clk_en:    1'b1,
        dom_ready: 1'b1,
        dom_gated: 1'b0
    };

    function automatic cg_outs_t cg_decode(input cg_state_e s);
        cg_outs_t o;
        o = CG_OUTS_RESET;
        case (s)
            CG_RUN: begin
                o = CG_OUTS_RESET;
            end
            CG_DRAIN: begin
                o.sleep_req = 1'b1;
                o.clk_en    = 1'b1;
                o.dom_ready = 1'b1;
                o.dom_gated = 1'b0;
            end
            CG_GATED: begin
                o.sleep_req = 1'b0;
                o.clk_en    = 1'b0;
                o.dom_ready = 1'b0;
                o.dom_gated = 1'b1;
            end
            CG_WAKE: begin
                o.sleep_req = 1'b0;
                o.clk_en    = 1'b1;
                o.dom_ready = 1'b0;
                o.dom_gated = 1'b0;
            end
            default: begin
                o = CG_OUTS_RESET;
            end
        endcase
        return o;
    endfunction

    function automatic int unsigned cg_cnt_width(input int unsigned n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/clk_gate_ctrl_chan.sv
// -----------------------------------------------------------------------------
// clk_gate_ctrl_chan
// Gating FSM for a single clock domain: idle counting, sleep handshake,
// gating and the settle period after ungating.
//
// Ports
//   clk             in   free-running ungated clock
//   rst             in   synchronous active-high reset
//   cfg_en          in   auto-gating enable for this domain
//   cfg_idle_thresh in   idle cycles required before gating (0 = disabled)
//   dom_busy        in   domain has work in flight
//   wake_req        in   requester wants the domain (level)
//   sleep_ack       in   domain quiescent, accepts gating (used only in DRAIN)
//   sleep_req       out  ask the domain to quiesce
//   clk_en          out  enable pin of the domain ICG
//   dom_ready       out  domain clocked and settled
//   dom_gated       out  status: domain clock is stopped
//
// All outputs come straight from flops loaded with the decode of the next
// state, so they change exactly when the state does and have no
// combinational path from any input.
// -----------------------------------------------------------------------------
module clk_gate_ctrl_chan
    import clk_gate_ctrl_pkg::*;
#(
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2   // must be >= 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_en,
    input  logic [IDLE_W-1:0] cfg_idle_thresh,
    input  logic              dom_busy,
    input  logic              wake_req,
    input  logic              sleep_ack,
    output logic              sleep_req,
    output logic              clk_en,
    output logic              dom_ready,
    output logic              dom_gated
);

    localparam int unsigned         WAKE_W    = cg_cnt_width(WAKE_CYC);
    localparam logic [WAKE_W-1:0]   WAKE_LAST = WAKE_W'(WAKE_CYC - 1);

    cg_state_e          state_reg, state_next;
    logic [IDLE_W-1:0]  idle_cnt_reg, idle_cnt_next;
    logic [WAKE_W-1:0]  wake_cnt_reg, wake_cnt_next;
    cg_outs_t           outs_reg;

    logic               gating_active;
    logic               idle;
    logic [IDLE_W:0]    idle_cnt_inc;
    logic [IDLE_W-1:0]  idle_cnt_sat;
    logic               thresh_hit;

    assign gating_active = cfg_en && (cfg_idle_thresh != '0);
    assign idle          = !dom_busy && !wake_req;

    // One extra bit so the +1 compare cannot wrap; this lets an all-ones
    // threshold still be reached.
    assign idle_cnt_inc  = {1'b0, idle_cnt_reg} + {{IDLE_W{1'b0}}, 1'b1};
    assign idle_cnt_sat  = idle_cnt_inc[IDLE_W] ? idle_cnt_reg : idle_cnt_inc[IDLE_W-1:0];

    // Live compare against the current threshold: "this idle cycle is the
    // T-th one", so sleep_req rises on the edge that ends it.
    assign thresh_hit    = idle_cnt_inc >= {1'b0, cfg_idle_thresh};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= CG_RUN;
            idle_cnt_reg <= '0;
            wake_cnt_reg <= '0;
            outs_reg     <= CG_OUTS_RESET;
        end else begin
            state_reg    <= state_next;
            idle_cnt_reg <= idle_cnt_next;
            wake_cnt_reg <= wake_cnt_next;
            outs_reg     <= cg_decode(state_next);
        end
    end

    always_comb begin
        state_next    = state_reg;
        idle_cnt_next = '0;          // the count only lives while in RUN
        wake_cnt_next = wake_cnt_reg;

        case (state_reg)
            CG_RUN: begin
                wake_cnt_next = '0;
                if (gating_active && idle) begin
                    if (thresh_hit) begin
                        state_next = CG_DRAIN;
                    end else begin
                        idle_cnt_next = idle_cnt_sat;
                    end
                end
            end

            CG_DRAIN: begin
                // Abort wins over a same-cycle sleep_ack.
                if (!gating_active || !idle) begin
                    state_next = CG_RUN;
                end else if (sleep_ack) begin
                    state_next = CG_GATED;
                end
            end

            CG_GATED: begin
                // dom_busy is meaningless here: the domain has no clock.
                if (wake_req || !gating_active) begin
                    state_next    = CG_WAKE;
                    wake_cnt_next = '0;
                end
            end

            CG_WAKE: begin
                // Fixed settle time; nothing can interrupt it.
                if (wake_cnt_reg == WAKE_LAST) begin
                    state_next    = CG_RUN;
                    wake_cnt_next = '0;
                end else begin
                    wake_cnt_next = wake_cnt_reg + WAKE_W'(1);
                end
            end

            default: begin
                state_next    = CG_RUN;
                wake_cnt_next = '0;
            end
        endcase
    end

    assign sleep_req = outs_reg.sleep_req;
    assign clk_en    = outs_reg.clk_en;
    assign dom_ready = outs_reg.dom_ready;
    assign dom_gated = outs_reg.dom_gated;

endmodule

// File: rtl/clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// clk_gate_ctrl
// Automatic clock-gating controller for N_DOM independent domains. Each
// domain gets its own clk_gate_ctrl_chan; this level only fans out the
// per-domain slices.
//
// Ports
//   clk             in   free-running ungated clock
//   rst             in   synchronous active-high reset
//   cfg_en          in   [N_DOM]          per-domain auto-gating enable
//   cfg_idle_thresh in   [N_DOM*IDLE_W]   per-domain idle threshold, domain d
//                                         at bits [d*IDLE_W +: IDLE_W]
//   dom_busy        in   [N_DOM]          domain has work in flight
//   wake_req        in   [N_DOM]          requester wants the domain
//   sleep_ack       in   [N_DOM]          domain accepts gating
//   sleep_req       out  [N_DOM]          quiesce request to the domain
//   clk_en          out  [N_DOM]          ICG enable
//   dom_ready       out  [N_DOM]          domain clocked and settled
//   dom_gated       out  [N_DOM]          domain clock stopped (status)
// -----------------------------------------------------------------------------
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int N_DOM    = 4,
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_DOM-1:0]        cfg_en,
    input  logic [N_DOM*IDLE_W-1:0] cfg_idle_thresh,
    input  logic [N_DOM-1:0]        dom_busy,
    input  logic [N_DOM-1:0]        wake_req,
    input  logic [N_DOM-1:0]        sleep_ack,
    output logic [N_DOM-1:0]        sleep_req,
    output logic [N_DOM-1:0]        clk_en,
    output logic [N_DOM-1:0]        dom_ready,
    output logic [N_DOM-1:0]        dom_gated
);

    generate
        for (genvar gi = 0; gi < N_DOM; gi++) begin : g_chan
            clk_gate_ctrl_chan #(
                .IDLE_W   (IDLE_W),
                .WAKE_CYC (WAKE_CYC)
            ) u_chan (
                .clk             (clk),
                .rst             (rst),
                .cfg_en          (cfg_en[gi]),
                .cfg_idle_thresh (cfg_idle_thresh[gi*IDLE_W +: IDLE_W]),
                .dom_busy        (dom_busy[gi]),
                .wake_req        (wake_req[gi]),
                .sleep_ack       (sleep_ack[gi]),
                .sleep_req       (sleep_req[gi]),
                .clk_en          (clk_en[gi]),
                .dom_ready       (dom_ready[gi]),
                .dom_gated       (dom_gated[gi])
            );
        end
    endgenerate

endmodule
